// File: rtl/data_ram_pkg.sv
// Shared definitions for the data RAM and the load/store unit: RISC-V funct3
// access encodings, default geometry and the alignment rule.
package data_ram_pkg;

  localparam logic [2:0] AT_B  = 3'b000;
  localparam logic [2:0] AT_H  = 3'b001;
  localparam logic [2:0] AT_W  = 3'b010;
  localparam logic [2:0] AT_BU = 3'b100;
  localparam logic [2:0] AT_HU = 3'b101;

  localparam int DATA_RAM_ADDR_W      = 14;
  localparam int DATA_RAM_DEPTH_WORDS = 4096;

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [2:0] at, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (at)
      AT_H, AT_HU: mis = lane[0];
      AT_W:        mis = (lane != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_ram_lane_fmt.sv
// Combinational lane formatter: load extraction with sign/zero extension, and
// store byte-enables with write data replicated across the byte lanes.
module data_ram_lane_fmt
  import data_ram_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  logic [2:0]  access_type,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rd_word[{lane, 3'b000} +: 8];
  assign half_s = lane[1] ? rd_word[31:16] : rd_word[15:0];

  // Load path: reserved encodings fall back to the whole word.
  always_comb begin
    load_data = rd_word;
    case (access_type)
      AT_B:    load_data = {{24{byte_s[7]}}, byte_s};
      AT_BU:   load_data = {24'h000000, byte_s};
      AT_H:    load_data = {{16{half_s[15]}}, half_s};
      AT_HU:   load_data = {16'h0000, half_s};
      AT_W:    load_data = rd_word;
      default: load_data = rd_word;
    endcase
  end

  // Store path: reserved encodings enable no lanes, so the write is dropped.
  always_comb begin
    byte_en = 4'b0000;
    wr_data = store_data;
    case (access_type)
      AT_B, AT_BU: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{store_data[7:0]}};
      end
      AT_H, AT_HU: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{store_data[15:0]}};
      end
      AT_W: begin
        byte_en = 4'b1111;
        wr_data = store_data;
      end
      default: begin
        byte_en = 4'b0000;
        wr_data = store_data;
      end
    endcase
  end

endmodule

// File: rtl/data_ram.sv
// Byte-addressable data RAM with combinational reads and byte-lane writes.
// Optional alignment checking is compiled in with DATA_RAM_ALIGN_CHECK_EN.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int ADDR_W      = DATA_RAM_ADDR_W,
  parameter int DEPTH_WORDS = DATA_RAM_DEPTH_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       dataIn,
  input  logic [2:0]        access_type,
  output logic [31:0]       dataOut,
  output logic              misaligned
);

  logic [31:0]       mem_r [DEPTH_WORDS];
  logic [ADDR_W-3:0] word_idx_s;
  logic [31:0]       rd_word_s;
  logic [31:0]       load_data_s;
  logic [3:0]        byte_en_s;
  logic [31:0]       wr_data_s;
  logic              align_err_s;
  logic              we_s;

  assign word_idx_s = addr[ADDR_W-1:2];
  assign rd_word_s  = mem_r[word_idx_s];

  data_ram_lane_fmt u_lane_fmt (
    .rd_word     (rd_word_s),
    .lane        (addr[1:0]),
    .access_type (access_type),
    .store_data  (dataIn),
    .load_data   (load_data_s),
    .byte_en     (byte_en_s),
    .wr_data     (wr_data_s)
  );

`ifdef DATA_RAM_ALIGN_CHECK_EN
  assign align_err_s = is_misaligned(access_type, addr[1:0]);
`else
  assign align_err_s = 1'b0;
`endif

  assign misaligned = align_err_s & ~reset;
  assign we_s       = wEn & ~align_err_s;

  // Misaligned reads return zero rather than a partially shifted word.
  always_comb begin
    dataOut = load_data_s;
    if (align_err_s) begin
      dataOut = 32'h0000_0000;
    end else begin
      dataOut = load_data_s;
    end
  end

  // Storage: asynchronous clear, then per-lane writes on the rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en_s[b]) begin
          mem_r[word_idx_s][b*8 +: 8] <= wr_data_s[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram against a byte-array reference model;
// honours DATA_RAM_ALIGN_CHECK_EN when it is defined.
module tb_data_ram;

  logic        clk;
  logic        reset;
  logic        wEn;
  logic [13:0] addr;
  logic [31:0] dataIn;
  logic [2:0]  access_type;
  logic [31:0] dataOut;
  logic        misaligned;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] ref_mem [0:16383];

  data_ram dut (
    .clk         (clk),
    .reset       (reset),
    .wEn         (wEn),
    .addr        (addr),
    .dataIn      (dataIn),
    .access_type (access_type),
    .dataOut     (dataOut),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_mis(input int a, input int at);
`ifdef DATA_RAM_ALIGN_CHECK_EN
    return ((at == 1 || at == 5) && (a % 2) != 0) || (at == 2 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input int a, input int at);
    int hb;
    int wb;
    logic [15:0] h;
    if (ref_mis(a, at)) return 32'h0;
    hb = a - (a % 2);
    wb = a - (a % 4);
    h  = {ref_mem[hb+1], ref_mem[hb]};
    case (at)
      0:       return 32'($signed(ref_mem[a]));
      4:       return 32'(ref_mem[a]);
      1:       return 32'($signed(h));
      5:       return 32'(h);
      default: return {ref_mem[wb+3], ref_mem[wb+2], ref_mem[wb+1], ref_mem[wb]};
    endcase
  endfunction

  task automatic ref_store(input int a, input int at, input logic [31:0] d, input logic en);
    int hb;
    int wb;
    hb = a - (a % 2);
    wb = a - (a % 4);
    if (!en || ref_mis(a, at)) return;
    case (at)
      0, 4: ref_mem[a] = d[7:0];
      1, 5: begin
        ref_mem[hb] = d[7:0];
        ref_mem[hb+1] = d[15:8];
      end
      2: for (int k = 0; k < 4; k++) ref_mem[wb+k] = d[k*8 +: 8];
      default: ;
    endcase
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 16384; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic drive_write(input int a, input int at, input logic [31:0] d, input logic en);
    @(negedge clk);
    addr = a[13:0];
    access_type = at[2:0];
    dataIn = d;
    wEn = en;
    @(posedge clk);
    ref_store(a, at, d, en);
    #1;
    wEn = 1'b0;
  endtask

  task automatic set_read(input int a, input int at);
    addr = a[13:0];
    access_type = at[2:0];
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ref_clear();
    repeat (2) @(posedge clk);
    #1;
    set_read(32'h0101, 2);
    total_cnt++;
    if (misaligned !== 1'b0) $display("FAIL reset_misaligned got %0b want 0", misaligned);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    set_read(32'h0100, 2);
    total_cnt++;
    if (dataOut !== 32'h0) $display("FAIL reset_read got %h want 00000000", dataOut);
    else pass_cnt++;
  endtask

  task automatic test_load_ext();
    int          a_tab [4] = '{32'h10, 32'h11, 32'h12, 32'h12};
    int          t_tab [4] = '{0, 4, 1, 5};
    logic [31:0] e_tab [4] = '{32'hFFFFFFF3, 32'h000000F2, 32'hFFFF8081, 32'h00008081};
    drive_write(32'h10, 2, 32'h8081F2F3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      set_read(a_tab[i], t_tab[i]);
      total_cnt++;
      if (dataOut !== e_tab[i]) $display("FAIL load_ext[%0d] got %h want %h", i, dataOut, e_tab[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_merge_and_suppress();
    drive_write(32'h20, 2, 32'h11223344, 1'b1);
    drive_write(32'h21, 0, 32'h000000AA, 1'b1);
    drive_write(32'h22, 1, 32'h0000BEEF, 1'b1);
    set_read(32'h20, 2);
    total_cnt++;
    if (dataOut !== 32'hBEEFAA44) $display("FAIL merge got %h want BEEFAA44", dataOut);
    else pass_cnt++;
    drive_write(32'h20, 2, 32'hFFFFFFFF, 1'b0);
    set_read(32'h20, 2);
    total_cnt++;
    if (dataOut !== 32'hBEEFAA44) $display("FAIL wen_low got %h want BEEFAA44", dataOut);
    else pass_cnt++;
    drive_write(32'h20, 7, 32'hFFFFFFFF, 1'b1);
    set_read(32'h20, 3);
    total_cnt++;
    if (dataOut !== 32'hBEEFAA44) $display("FAIL reserved_type got %h want BEEFAA44", dataOut);
    else pass_cnt++;
  endtask

  task automatic test_read_during_write();
    drive_write(32'h40, 2, 32'hA5A5_0001, 1'b1);
    @(negedge clk);
    addr = 14'h0040;
    access_type = 3'b010;
    dataIn = 32'h5A5A_0002;
    wEn = 1'b1;
    #1;
    total_cnt++;
    if (dataOut !== 32'hA5A50001) $display("FAIL rdw_old got %h want A5A50001", dataOut);
    else pass_cnt++;
    @(posedge clk);
    ref_store(32'h40, 2, 32'h5A5A0002, 1'b1);
    #1;
    wEn = 1'b0;
    total_cnt++;
    if (dataOut !== 32'h5A5A0002) $display("FAIL rdw_new got %h want 5A5A0002", dataOut);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int a;
    int at;
    logic [31:0] exp;
    for (int n = 0; n < 300; n++) begin
      a  = ($urandom % 2 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(16320, 16383));
      at = int'($urandom % 8);
      drive_write(a, at, $urandom, ($urandom % 4) != 0);
      a  = ($urandom % 2 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(16320, 16383));
      at = int'($urandom % 8);
      set_read(a, at);
      exp = ref_load(a, at);
      total_cnt++;
      if (dataOut !== exp) $display("FAIL rand_read a=%h t=%0d got %h want %h", a, at, dataOut, exp);
      else pass_cnt++;
      total_cnt++;
      if (misaligned !== ref_mis(a, at))
        $display("FAIL rand_mis a=%h t=%0d got %0b want %0b", a, at, misaligned, ref_mis(a, at));
      else pass_cnt++;
    end
  endtask

  task automatic test_top_word_reset();
    drive_write(32'h3FFC, 2, 32'hDEADBEEF, 1'b1);
    set_read(32'h3FFC, 2);
    total_cnt++;
    if (dataOut !== 32'hDEADBEEF) $display("FAIL top_word got %h want DEADBEEF", dataOut);
    else pass_cnt++;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (dataOut !== 32'h0) $display("FAIL reset_async got %h want 00000000", dataOut);
    else pass_cnt++;
    ref_clear();
    set_read(32'h3FFD, 2);
    total_cnt++;
    if (misaligned !== 1'b0) $display("FAIL reset_mis got %0b want 0", misaligned);
    else pass_cnt++;
    addr = 14'h3FFC;
    dataIn = 32'hCAFE0000;
    wEn = 1'b1;
    @(posedge clk);
    #1;
    wEn = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    set_read(32'h3FFC, 2);
    total_cnt++;
    if (dataOut !== 32'h0) $display("FAIL write_in_reset got %h want 00000000", dataOut);
    else pass_cnt++;
    drive_write(32'h3FFC, 2, 32'h12345678, 1'b1);
    set_read(32'h3FFC, 2);
    total_cnt++;
    if (dataOut !== 32'h12345678) $display("FAIL post_reset_write got %h want 12345678", dataOut);
    else pass_cnt++;
  endtask

  task automatic test_misaligned();
    logic [31:0] exp30;
    logic        exp_mis;
    drive_write(32'h30, 2, 32'h01020304, 1'b1);
`ifdef DATA_RAM_ALIGN_CHECK_EN
    exp30 = 32'h01020304;
    exp_mis = 1'b1;
`else
    exp30 = 32'hCAFEF00D;
    exp_mis = 1'b0;
`endif
    set_read(32'h31, 2);
    total_cnt++;
    if (misaligned !== exp_mis) $display("FAIL mis_flag got %0b want %0b", misaligned, exp_mis);
    else pass_cnt++;
    drive_write(32'h31, 2, 32'hCAFEF00D, 1'b1);
    set_read(32'h30, 2);
    total_cnt++;
    if (dataOut !== exp30) $display("FAIL mis_store got %h want %h", dataOut, exp30);
    else pass_cnt++;
    set_read(32'h31, 2);
    total_cnt++;
    if (dataOut !== ref_load(32'h31, 2)) $display("FAIL mis_read got %h want %h", dataOut, ref_load(32'h31, 2));
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    wEn = 1'b0;
    addr = 14'h0000;
    dataIn = 32'h0;
    access_type = 3'b010;
    test_reset();
    test_load_ext();
    test_merge_and_suppress();
    test_read_during_write();
    test_random();
    test_top_word_reset();
    test_misaligned();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
